// File: rtl/call_stack.sv
// Return-address stack for call/return handling beside the decode stage.
// Push stores an address, pop returns the newest address one cycle later with a valid strobe.
module call_stack #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [PTR_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  top_idx;
  logic [PTR_WIDTH-1:0]  wr_idx;
  logic                  pop_ok;
  logic                  wr_en;
  logic                  inc;
  logic                  dec;
  logic                  ovf_set;
  logic                  unf_set;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_WIDTH+1)'(DEPTH));
  assign top_idx = PTR_WIDTH'(count - 1'b1);
  assign top_data = empty ? '0 : mem[top_idx];

  // A push alongside an accepted pop overwrites the top entry in place;
  // a push alongside a rejected pop (empty stack) behaves as a plain push.
  assign pop_ok  = pop && !empty;
  assign wr_en   = push && (pop_ok || !full);
  assign wr_idx  = pop_ok ? top_idx : count[PTR_WIDTH-1:0];
  assign inc     = push && !pop_ok && !full;
  assign dec     = pop_ok && !push;
  assign ovf_set = push && !pop_ok && full;
  assign unf_set = pop && empty;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= pop_ok;
      if (pop_ok) begin
        pop_data <= mem[top_idx];
      end
      if (inc) begin
        count <= count + 1'b1;
      end else if (dec) begin
        count <= count - 1'b1;
      end
      // New errors take priority over a simultaneous clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (unf_set) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Directed self-checking bench for call_stack with immediate assertions.
module tb_call_stack;

  logic        clk;
  logic        rst;
  logic        push;
  logic        pop;
  logic [31:0] push_data;
  logic        clear_err;
  logic [31:0] pop_data;
  logic        pop_valid;
  logic [31:0] top_data;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int compared = 0;
  int mismatched = 0;

  call_stack #(.DATA_WIDTH(32), .DEPTH(16), .PTR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clear_err(clear_err), .pop_data(pop_data), .pop_valid(pop_valid),
    .top_data(top_data), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of requests, then samples 1 time unit after the rising edge.
  task automatic applyStimulus(input logic p, input logic q, input logic [31:0] d, input logic c);
    @(negedge clk);
    push = p; pop = q; push_data = d; clear_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0; clear_err = 1'b0;
    #12;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_pop_valid", 32'(pop_valid), 32'd0);
    checkOutput("rst_pop_data", pop_data, 32'd0);
    checkOutput("rst_top", top_data, 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_unf", 32'(underflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1, 0, 32'h0040_0010, 0);
    checkOutput("push1_top", top_data, 32'h0040_0010);
    applyStimulus(1, 0, 32'h0040_0020, 0);
    applyStimulus(1, 0, 32'h0040_0030, 0);
    checkOutput("push3_count", 32'(count), 32'd3);
    checkOutput("push3_top", top_data, 32'h0040_0030);
    checkOutput("push3_empty", 32'(empty), 32'd0);
    checkOutput("push3_full", 32'(full), 32'd0);

    applyStimulus(0, 1, 32'h0, 0);
    checkOutput("pop1_valid", 32'(pop_valid), 32'd1);
    checkOutput("pop1_data", pop_data, 32'h0040_0030);
    applyStimulus(0, 1, 32'h0, 0);
    checkOutput("pop2_valid", 32'(pop_valid), 32'd1);
    checkOutput("pop2_data", pop_data, 32'h0040_0020);
    applyStimulus(0, 1, 32'h0, 0);
    checkOutput("pop3_valid", 32'(pop_valid), 32'd1);
    checkOutput("pop3_data", pop_data, 32'h0040_0010);
    checkOutput("pop3_count", 32'(count), 32'd0);
    checkOutput("pop3_empty", 32'(empty), 32'd1);
    checkOutput("pop3_top", top_data, 32'd0);

    applyStimulus(0, 1, 32'h0, 0);
    checkOutput("unf_valid", 32'(pop_valid), 32'd0);
    checkOutput("unf_data_hold", pop_data, 32'h0040_0010);
    checkOutput("unf_flag", 32'(underflow), 32'd1);
    checkOutput("unf_count", 32'(count), 32'd0);
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("unf_sticky", 32'(underflow), 32'd1);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("unf_cleared", 32'(underflow), 32'd0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, 32'h1000 + 32'(4 * i), 0);
      if (i == 15) begin
        checkOutput("fill_full16", 32'(full), 32'd1);
        checkOutput("fill_no_ovf_yet", 32'(overflow), 32'd0);
      end
    end
    checkOutput("ovf_full", 32'(full), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd16);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_top", top_data, 32'h103C);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 32'h0, 0);
      checkOutput($sformatf("drain_valid_%0d", i), 32'(pop_valid), 32'd1);
      checkOutput($sformatf("drain_data_%0d", i), pop_data, 32'h103C - 32'(4 * i));
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    checkOutput("drain_valid_end", 32'(pop_valid), 32'd0);

    applyStimulus(1, 0, 32'hA0, 0);
    applyStimulus(1, 0, 32'hB0, 0);
    applyStimulus(1, 1, 32'hC0, 0);
    checkOutput("rep_data", pop_data, 32'hB0);
    checkOutput("rep_valid", 32'(pop_valid), 32'd1);
    checkOutput("rep_count", 32'(count), 32'd2);
    checkOutput("rep_top", top_data, 32'hC0);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, 0, 32'h200 + 32'(i), 0);
    end
    checkOutput("rep_full", 32'(full), 32'd1);
    applyStimulus(1, 1, 32'h77, 0);
    checkOutput("repfull_data", pop_data, 32'h20D);
    checkOutput("repfull_valid", 32'(pop_valid), 32'd1);
    checkOutput("repfull_count", 32'(count), 32'd16);
    checkOutput("repfull_top", top_data, 32'h77);
    checkOutput("repfull_no_ovf", 32'(overflow), 32'd0);
    applyStimulus(1, 0, 32'h88, 1);
    checkOutput("set_beats_clear", 32'(overflow), 32'd1);
    checkOutput("full_drop_top", top_data, 32'h77);

    applyStimulus(0, 0, 32'h0, 0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    applyStimulus(0, 1, 32'h0, 0);
    checkOutput("reset_flag_unf", 32'(underflow), 32'd1);
    checkOutput("reset_flag_ovf", 32'(overflow), 32'd0);
    applyStimulus(1, 0, 32'h55, 1);
    applyStimulus(1, 1, 32'h66, 0);
    checkOutput("pre_arst_valid", 32'(pop_valid), 32'd1);
    checkOutput("pre_arst_data", pop_data, 32'h55);
    push = 1'b0; pop = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_empty", 32'(empty), 32'd1);
    checkOutput("arst_valid", 32'(pop_valid), 32'd0);
    checkOutput("arst_data", pop_data, 32'd0);
    checkOutput("arst_top", top_data, 32'd0);
    checkOutput("arst_ovf", 32'(overflow), 32'd0);
    checkOutput("arst_unf", 32'(underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
